ibex_multdiv_issue: RTL and testbench

- Issue and sequencing stage directly upstream of the fast mult/div unit.
- Accepts one MUL/DIV request from the ID stage over a valid/ready handshake and latches its operands.
- Drives the unit's mult_en/div_en, operator, signed mode and divide-by-zero flag until the unit reports ready, then captures the result.
- Presents the result to writeback over a valid/ready handshake. Also absorbs pipeline flushes without corrupting the unit's internal FSMs.

---
 rtl/ibex_multdiv_issue.sv | 137 +++++++++++++
 tb/tb_ibex_multdiv_issue.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ibex_multdiv_issue.sv
// Issue/sequencing stage in front of the fast mult/div unit: latches one request,
// holds the unit's enables until it reports ready, and hands the result to writeback.
package ibex_multdiv_issue_pkg;
  typedef enum logic [1:0] {
    MD_OP_MULL = 2'b00,
    MD_OP_MULH = 2'b01,
    MD_OP_DIV  = 2'b10,
    MD_OP_REM  = 2'b11
  } md_op_e;
endpackage

module ibex_multdiv_issue
  import ibex_multdiv_issue_pkg::*;
#(
  parameter int MAX_CYCLES = 40,
  parameter int CNT_W      = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  md_op_e      req_op_i,
  input  logic [1:0]  req_signed_i,
  input  logic [31:0] req_a_i,
  input  logic [31:0] req_b_i,
  input  logic [4:0]  req_rd_i,
  input  logic        flush_i,
  output logic        mult_en_o,
  output logic        div_en_o,
  output md_op_e      operator_o,
  output logic [1:0]  signed_mode_o,
  output logic [31:0] op_a_o,
  output logic [31:0] op_b_o,
  output logic        equal_to_zero_o,
  input  logic [31:0] multdiv_result_i,
  input  logic        md_ready_i,
  output logic        wb_valid_o,
  input  logic        wb_ready_i,
  output logic [31:0] wb_data_o,
  output logic [4:0]  wb_rd_o,
  output logic        timeout_o
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP, DRAIN} state_e;

  state_e             state_q;
  md_op_e             op_q;
  logic [1:0]         signed_q;
  logic [31:0]        a_q;
  logic [31:0]        b_q;
  logic [4:0]         rd_q;
  logic               ez_q;
  logic [31:0]        wb_data_q;
  logic [CNT_W-1:0]   cnt_q;

  logic is_mult;
  logic active;
  logic wd_fire;
  logic accept;

  assign is_mult = (op_q == MD_OP_MULL) || (op_q == MD_OP_MULH);
  assign active  = (state_q == BUSY) || (state_q == DRAIN);
  // A ready in the last allowed cycle still counts as a normal completion.
  assign wd_fire = active && !md_ready_i && (cnt_q == CNT_W'(MAX_CYCLES - 1));
  assign accept  = (state_q == IDLE) && req_valid_i && !flush_i;

  assign req_ready_o     = (state_q == IDLE) && !flush_i;
  assign mult_en_o       = active && is_mult;
  assign div_en_o        = active && !is_mult;
  assign operator_o      = op_q;
  assign signed_mode_o   = signed_q;
  assign op_a_o          = a_q;
  assign op_b_o          = b_q;
  assign equal_to_zero_o = ez_q;
  assign wb_valid_o      = (state_q == RESP);
  assign wb_data_o       = wb_data_q;
  assign wb_rd_o         = rd_q;
  assign timeout_o       = wd_fire;

  // Enables stay up in DRAIN because the unit's FSM cannot be aborted mid-operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      op_q      <= MD_OP_MULL;
      signed_q  <= 2'b00;
      a_q       <= 32'h0;
      b_q       <= 32'h0;
      rd_q      <= 5'h0;
      ez_q      <= 1'b0;
      wb_data_q <= 32'h0;
      cnt_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            op_q     <= req_op_i;
            signed_q <= req_signed_i;
            a_q      <= req_a_i;
            b_q      <= req_b_i;
            rd_q     <= req_rd_i;
            ez_q     <= (req_b_i == 32'h0);
            cnt_q    <= '0;
            state_q  <= BUSY;
          end
        end
        BUSY: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (md_ready_i) begin
            if (flush_i) begin
              state_q <= IDLE;
            end else begin
              wb_data_q <= multdiv_result_i;
              state_q   <= RESP;
            end
          end else if (wd_fire) begin
            state_q <= IDLE;
          end else if (flush_i) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (md_ready_i || wd_fire) begin
            state_q <= IDLE;
          end
        end
        RESP: begin
          if (flush_i || wb_ready_i) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ibex_multdiv_issue.sv
// Self-checking bench for ibex_multdiv_issue with a behavioural mult/div unit model.
module tb_ibex_multdiv_issue;
  import ibex_multdiv_issue_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  md_op_e      req_op_i = MD_OP_MULL;
  logic [1:0]  req_signed_i = 2'b00;
  logic [31:0] req_a_i = 32'h0;
  logic [31:0] req_b_i = 32'h0;
  logic [4:0]  req_rd_i = 5'h0;
  logic        flush_i = 1'b0;
  logic        mult_en_o;
  logic        div_en_o;
  md_op_e      operator_o;
  logic [1:0]  signed_mode_o;
  logic [31:0] op_a_o;
  logic [31:0] op_b_o;
  logic        equal_to_zero_o;
  logic [31:0] multdiv_result_i;
  logic        md_ready_i;
  logic        wb_valid_o;
  logic        wb_ready_i = 1'b0;
  logic [31:0] wb_data_o;
  logic [4:0]  wb_rd_o;
  logic        timeout_o;

  logic        force_md_low = 1'b0;
  int          en_cnt;
  int          unit_lat;
  int          checks = 0;
  int          errors = 0;

  typedef struct {
    md_op_e      op;
    logic [1:0]  sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_data;
    int          exp_lat;
  } vec_t;

  ibex_multdiv_issue dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_op_i(req_op_i), .req_signed_i(req_signed_i),
    .req_a_i(req_a_i), .req_b_i(req_b_i), .req_rd_i(req_rd_i),
    .flush_i(flush_i),
    .mult_en_o(mult_en_o), .div_en_o(div_en_o),
    .operator_o(operator_o), .signed_mode_o(signed_mode_o),
    .op_a_o(op_a_o), .op_b_o(op_b_o), .equal_to_zero_o(equal_to_zero_o),
    .multdiv_result_i(multdiv_result_i), .md_ready_i(md_ready_i),
    .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i),
    .wb_data_o(wb_data_o), .wb_rd_o(wb_rd_o), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  function automatic bit is_mul(md_op_e op);
    return (op == MD_OP_MULL) || (op == MD_OP_MULH);
  endfunction

  // Architectural result of a RISC-V M-extension op, from plain 64-bit arithmetic.
  function automatic logic [31:0] ref_result(md_op_e op, logic [1:0] s, logic [31:0] a, logic [31:0] b);
    longint pa;
    longint pb;
    logic [63:0] p;
    int sa;
    int sb;
    pa = s[0] ? longint'($signed(a)) : longint'({32'h0, a});
    pb = s[1] ? longint'($signed(b)) : longint'({32'h0, b});
    p  = pa * pb;
    sa = a;
    sb = b;
    case (op)
      MD_OP_MULL: return p[31:0];
      MD_OP_MULH: return p[63:32];
      MD_OP_DIV: begin
        if (b == 32'h0) return 32'hFFFF_FFFF;
        if (s == 2'b11) begin
          if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
          return sa / sb;
        end
        return a / b;
      end
      default: begin
        if (b == 32'h0) return a;
        if (s == 2'b11) begin
          if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
          return sa % sb;
        end
        return a % b;
      end
    endcase
  endfunction

  function automatic int ref_lat(md_op_e op, logic [31:0] b);
    case (op)
      MD_OP_MULL: return 3;
      MD_OP_MULH: return 4;
      default:    return (b == 32'h0) ? 2 : 37;
    endcase
  endfunction

  // Unit model: raises ready in the Nth enable-high cycle, N taken from the unit's own inputs.
  always_comb begin
    unit_lat = 2;
    if (operator_o == MD_OP_MULL)      unit_lat = 3;
    else if (operator_o == MD_OP_MULH) unit_lat = 4;
    else if (!equal_to_zero_o)         unit_lat = 37;
  end

  assign md_ready_i = !force_md_low && (mult_en_o || div_en_o) && (en_cnt == unit_lat - 1);
  assign multdiv_result_i = ref_result(operator_o, signed_mode_o, op_a_o, op_b_o);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      en_cnt <= 0;
    else if (mult_en_o || div_en_o)  en_cnt <= md_ready_i ? 0 : en_cnt + 1;
    else                             en_cnt <= 0;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One full request/response transaction, writeback stalled for 'hold' cycles.
  task automatic applyStimulus(input vec_t v, input logic [4:0] rd, input int hold);
    int cyc;
    bit done;
    bit kind_ok;
    bit stable_ok;
    bit hold_ok;
    @(negedge clk);
    req_valid_i  = 1'b1;
    req_op_i     = v.op;
    req_signed_i = v.sgn;
    req_a_i      = v.a;
    req_b_i      = v.b;
    req_rd_i     = rd;
    wb_ready_i   = (hold == 0);
    #1 checkOutput("req_ready_idle", req_ready_o, 1);
    @(negedge clk);
    req_valid_i = 1'b0;
    req_a_i     = $urandom;
    req_b_i     = $urandom;
    req_rd_i    = 5'($urandom);
    #1 checkOutput("equal_to_zero", equal_to_zero_o, v.b == 32'h0);
    cyc = 0; done = 0; kind_ok = 1; stable_ok = 1; hold_ok = 1;
    for (int i = 0; i < 60 && !done; i++) begin
      if (wb_valid_o) done = 1;
      else begin
        if (mult_en_o || div_en_o) cyc++;
        if (mult_en_o !== is_mul(v.op) || div_en_o !== !is_mul(v.op)) kind_ok = 0;
        if (op_a_o !== v.a || op_b_o !== v.b || operator_o !== v.op ||
            signed_mode_o !== v.sgn || req_ready_o !== 1'b0) stable_ok = 0;
        @(negedge clk); #1;
      end
    end
    checkOutput("wb_valid_seen", done, 1);
    checkOutput("enable_cycles", cyc, v.exp_lat);
    checkOutput("enable_kind", kind_ok, 1);
    checkOutput("op_stable", stable_ok, 1);
    checkOutput("wb_data", wb_data_o, v.exp_data);
    checkOutput("wb_rd", wb_rd_o, rd);
    for (int h = 0; h < hold; h++) begin
      if (wb_valid_o !== 1'b1 || wb_data_o !== v.exp_data || wb_rd_o !== rd ||
          req_ready_o !== 1'b0) hold_ok = 0;
      @(negedge clk); #1;
    end
    if (hold > 0) checkOutput("wb_hold_stable", hold_ok, 1);
    wb_ready_i = 1'b1;
    @(negedge clk); #1;
    checkOutput("wb_valid_drop", wb_valid_o, 0);
    checkOutput("req_ready_back", req_ready_o, 1);
  endtask

  initial begin
    vec_t vecs[7];
    vec_t rv;
    int cyc;
    int tcyc;
    int pulses;
    bit saw_wb;
    bit done;

    vecs[0] = '{MD_OP_MULL, 2'b00, 32'd7,         32'd6,         32'h0000_002A, 3};
    vecs[1] = '{MD_OP_MULH, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 4};
    vecs[2] = '{MD_OP_MULH, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 4};
    vecs[3] = '{MD_OP_DIV,  2'b00, 32'd100,       32'd0,         32'hFFFF_FFFF, 2};
    vecs[4] = '{MD_OP_REM,  2'b00, 32'd100,       32'd0,         32'h0000_0064, 2};
    vecs[5] = '{MD_OP_REM,  2'b11, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 37};
    vecs[6] = '{MD_OP_DIV,  2'b00, 32'd1000,      32'd3,         32'h0000_014D, 37};

    // Reset state
    #3;
    checkOutput("rst_req_ready", req_ready_o, 1);
    checkOutput("rst_wb_valid", wb_valid_o, 0);
    checkOutput("rst_enables", {mult_en_o, div_en_o}, 0);
    checkOutput("rst_timeout", timeout_o, 0);
    checkOutput("rst_op_a", op_a_o, 0);
    checkOutput("rst_wb_data", wb_data_o, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors
    for (int i = 0; i < 7; i++) applyStimulus(vecs[i], 5'(i + 1), 0);

    // Writeback stalled for 10 cycles
    applyStimulus(vecs[0], 5'd17, 10);

    // Request together with flush in IDLE is refused
    @(negedge clk);
    req_valid_i = 1'b1; flush_i = 1'b1; req_op_i = MD_OP_MULL; req_a_i = 32'd3; req_b_i = 32'd4;
    #1 checkOutput("flush_idle_ready", req_ready_o, 0);
    @(negedge clk);
    req_valid_i = 1'b0; flush_i = 1'b0;
    #1 checkOutput("flush_idle_no_accept", {mult_en_o, div_en_o}, 0);

    // Flush during a divide: enable held to completion, result discarded
    @(negedge clk);
    req_valid_i = 1'b1; req_op_i = MD_OP_DIV; req_signed_i = 2'b00;
    req_a_i = 32'd1000; req_b_i = 32'd3; req_rd_i = 5'd9; wb_ready_i = 1'b1;
    @(negedge clk);
    req_valid_i = 1'b0;
    cyc = 0; saw_wb = 0;
    for (int i = 0; i < 60; i++) begin
      #1;
      if (mult_en_o || div_en_o) cyc++;
      if (wb_valid_o) saw_wb = 1;
      flush_i = (cyc == 5) && div_en_o;
      @(negedge clk);
    end
    flush_i = 1'b0;
    checkOutput("drain_enable_cycles", cyc, 37);
    checkOutput("drain_no_wb", saw_wb, 0);
    applyStimulus(vecs[6], 5'd10, 0);

    // Flush and wb_ready together in RESP: flush wins, result dropped
    @(negedge clk);
    req_valid_i = 1'b1; req_op_i = MD_OP_MULL; req_signed_i = 2'b00;
    req_a_i = 32'd5; req_b_i = 32'd5; req_rd_i = 5'd3; wb_ready_i = 1'b0;
    @(negedge clk);
    req_valid_i = 1'b0;
    done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      #1;
      if (wb_valid_o) done = 1;
      else @(negedge clk);
    end
    checkOutput("resp_reached", done, 1);
    checkOutput("resp_data", wb_data_o, 32'd25);
    flush_i = 1'b1; wb_ready_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    #1 checkOutput("resp_flush_valid", wb_valid_o, 0);
    checkOutput("resp_flush_idle", req_ready_o, 1);

    // Watchdog: unit never answers
    force_md_low = 1'b1;
    @(negedge clk);
    req_valid_i = 1'b1; req_op_i = MD_OP_MULH; req_a_i = 32'd9; req_b_i = 32'd9;
    @(negedge clk);
    req_valid_i = 1'b0;
    cyc = 0; tcyc = 0; pulses = 0; saw_wb = 0;
    for (int i = 0; i < 50; i++) begin
      #1;
      if (mult_en_o || div_en_o) cyc++;
      if (timeout_o) begin pulses++; tcyc = cyc; end
      if (wb_valid_o) saw_wb = 1;
      @(negedge clk);
    end
    force_md_low = 1'b0;
    #1;
    checkOutput("timeout_pulses", pulses, 1);
    checkOutput("timeout_cycle", tcyc, 40);
    checkOutput("timeout_enable_cycles", cyc, 40);
    checkOutput("timeout_no_wb", saw_wb, 0);
    checkOutput("timeout_idle", req_ready_o, 1);

    // Asynchronous reset in the middle of a divide
    @(negedge clk);
    req_valid_i = 1'b1; req_op_i = MD_OP_DIV; req_a_i = 32'd77; req_b_i = 32'd5;
    @(negedge clk);
    req_valid_i = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_rst_enable", div_en_o, 0);
    checkOutput("async_rst_ready", req_ready_o, 1);
    checkOutput("async_rst_op_b", op_b_o, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Randomised transactions against the reference model
    for (int i = 0; i < 25; i++) begin
      rv.op  = md_op_e'($urandom_range(0, 3));
      rv.sgn = 2'($urandom);
      rv.a   = $urandom;
      rv.b   = ($urandom_range(0, 4) == 0) ? 32'h0 : $urandom;
      rv.exp_data = ref_result(rv.op, rv.sgn, rv.a, rv.b);
      rv.exp_lat  = ref_lat(rv.op, rv.b);
      applyStimulus(rv, 5'($urandom), $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
